btn_debounce_multi: RTL and testbench
=====================================

// Module: btn_debounce_multi
// PURPOSE
//  Parametrised N-channel push-button conditioner: synchronise, debounce by
//  sampled integration, emit clean level plus one-cycle press/release pulses.
//  Replaces per-button divider debouncer + external one-shot flop in board tops.
//  Sits between raw board buttons and control FSMs (dice, counters, menus).
// PARAMETERS
//  N_CH        2         number of independent button channels (1..16)
//  DIV_CNT     1250000   CLK cycles per sample tick (>=1; 1 = tick every cycle)
//  STABLE_N    3         consecutive mismatching ticks required to flip level (>=1)
//  ACTIVE_LOW  1         1: raw input low = pressed; 0: raw high = pressed
//  HOLD_TICKS  50        ticks held before first repeat (AUTOREPEAT_EN only)
//  RPT_TICKS   10        ticks between subsequent repeats (AUTOREPEAT_EN only)
// PORTS
//  CLK      in   1     system clock, all logic on rising edge
//  RST      in   1     asynchronous, active-low reset
//  BTN_RAW  in   N_CH  raw asynchronous button pins
//  LEVEL    out  N_CH  debounced state, 1 = pressed (polarity-normalised)
//  PRESS    out  N_CH  1-cycle pulse on LEVEL 0->1
//  RELEASE  out  N_CH  1-cycle pulse on LEVEL 1->0
//  REPEAT   out  N_CH  1-cycle auto-repeat pulse (tied 0 without AUTOREPEAT_EN)
//  TICK     out  1     1-cycle sample strobe, exported for debug/other timers
// BEHAVIOUR
//  - Reset (RST=0, async): LEVEL/PRESS/RELEASE/REPEAT/TICK = 0; synchroniser
//    flops = inactive raw level; channel counters = 0; prescaler = DIV_CNT-1.
//  - Prescaler: down-counter; TICK=1 in cycle count==0, reloads DIV_CNT-1 next
//    edge. First TICK exactly DIV_CNT cycles after reset release. DIV_CNT=1 ->
//    TICK constantly 1.
//  - Sync: 2-flop synchroniser per channel, then XOR with ACTIVE_LOW -> S[i].
//  - Integrator per channel, width $clog2(STABLE_N+1), updated only on TICK:
//    S[i]==LEVEL[i] -> cnt=0; else cnt+1; when mismatch seen and cnt==STABLE_N-1
//    -> LEVEL[i] toggles, cnt=0. Any matching tick aborts (bounce rejection).
//  - PRESS/RELEASE registered; asserted in the same cycle LEVEL first shows
//    new value; never both high; high for exactly one cycle.
//  - Latency raw edge -> LEVEL: 2 sync cycles + wait to next TICK +
//    (STABLE_N-1)*DIV_CNT cycles; max 2 + STABLE_N*DIV_CNT.
//  - Channels fully independent; simultaneous events on several channels
//    produce simultaneous pulses. Counters saturate-free by construction.
//  - RST asserted mid-debounce: all state cleared immediately, no pulse emitted
//    on release of reset even if button held (press pulse follows after
//    normal debounce latency).
// CONFIGURATION
//  - Macro BTN_DEBOUNCE_AUTOREPEAT_EN defined: per-channel hold counter
//    (ticks while LEVEL=1); REPEAT pulses once on the TICK where held count
//    reaches HOLD_TICKS, then every RPT_TICKS ticks; cleared when LEVEL=0.
//  - Undefined: no hold counters synthesised, REPEAT = 0, HOLD/RPT ignored.
// STRUCTURE
//  - Package debounce_pkg: DIV_W width function, level-polarity constants,
//    default DIV_CNT for 12.5 MHz/100 ms.
//  - Sub-module debounce_tick (prescaler, outputs TICK); one instance shared
//    by all channels. Channel logic in a generate loop inside top.
// TESTING (bench: N_CH=2, DIV_CNT=4, STABLE_N=3, ACTIVE_LOW=1, HOLD=4, RPT=2)
//  1 Reset: hold RST=0 10 cycles, BTN_RAW=2'b11 -> all outputs 0; TICK first
//    high at cycle 4 after release, then every 4 cycles.
//  2 Clean press ch0: BTN_RAW[0] 1->0 held -> LEVEL[0]=1 and PRESS[0] 1 cycle
//    within 2+12 cycles; ch1 outputs unchanged.
//  3 Bounce: ch0 low for 2 ticks, high 1 tick, repeated 5x -> LEVEL stays 0,
//    no PRESS; then stable low -> press after 3 ticks.
//  4 Release + simultaneous: both pressed, both released same cycle ->
//    RELEASE=2'b11 in same cycle, LEVEL=0.
//  5 Reset mid-debounce: ch0 low, RST pulsed after 2 ticks -> outputs 0,
//    PRESS only after full 3 ticks post-reset.
//  6 AUTOREPEAT_EN: ch1 held 20 ticks -> REPEAT[1] at hold ticks 4,6,8,...;
//    none after release; without macro REPEAT=0 throughout.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel push-button debouncer.
// Optional auto-repeat is enabled with macro BTN_DEBOUNCE_AUTOREPEAT_EN.
package debounce_pkg;

  // Debounced level encoding, after polarity normalisation.
  localparam logic LVL_PRESSED  = 1'b1;
  localparam logic LVL_RELEASED = 1'b0;

  // 12.5 MHz system clock, 100 ms between samples.
  localparam int unsigned DEFAULT_DIV_CNT = 1250000;

  // Bits needed to hold a down-counter value in 0..n-1 (never less than 1).
  function automatic int unsigned div_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_tick.sv
// Sample-tick prescaler: a down-counter that strobes TICK for one cycle every
// DIV_CNT cycles. The first strobe follows DIV_CNT cycles after reset release.
module debounce_tick
  import debounce_pkg::*;
#(
  parameter int unsigned DIV_CNT = DEFAULT_DIV_CNT
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  localparam int unsigned  CNT_W  = div_w(DIV_CNT);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV_CNT - 1);

  logic [CNT_W-1:0] cnt;

  // TICK is registered off the terminal count so it is clean (0) in reset,
  // and stays high continuously when DIV_CNT is 1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt  <= RELOAD;
      TICK <= 1'b0;
    end else begin
      TICK <= (cnt == '0);
      if (cnt == '0) begin
        cnt <= RELOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel button conditioner: 2-flop sync, tick-sampled integrating debounce,
// clean level plus press/release pulses. Auto-repeat via BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned DIV_CNT    = DEFAULT_DIV_CNT,
  parameter int unsigned STABLE_N   = 3,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned HOLD_TICKS = 50,
  parameter int unsigned RPT_TICKS  = 10
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] BTN_RAW,
  output logic [N_CH-1:0] LEVEL,
  output logic [N_CH-1:0] PRESS,
  output logic [N_CH-1:0] RELEASE,
  output logic [N_CH-1:0] REPEAT,
  output logic            TICK
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_N - 1);
  localparam logic [N_CH-1:0]  RAW_IDLE = {N_CH{ACTIVE_LOW}};

  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("btn_debounce_multi: N_CH must be in 1..16");
  end
  if (DIV_CNT < 1 || STABLE_N < 1) begin : g_bad_timing
    $error("btn_debounce_multi: DIV_CNT and STABLE_N must be at least 1");
  end
  if (HOLD_TICKS < 1 || RPT_TICKS < 1) begin : g_bad_repeat
    $error("btn_debounce_multi: HOLD_TICKS and RPT_TICKS must be at least 1");
  end

  logic            tick;
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;
  logic [N_CH-1:0] s_norm;

  debounce_tick #(
    .DIV_CNT (DIV_CNT)
  ) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (tick)
  );

  assign TICK = tick;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= RAW_IDLE;
      sync2 <= RAW_IDLE;
    end else begin
      sync1 <= BTN_RAW;
      sync2 <= sync1;
    end
  end

  // 1 = pressed regardless of board polarity.
  assign s_norm = sync2 ^ RAW_IDLE;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned      RPT_MAX   = (HOLD_TICKS > RPT_TICKS) ? HOLD_TICKS : RPT_TICKS;
  localparam int unsigned      RPT_W     = div_w(RPT_MAX);
  localparam logic [RPT_W-1:0] HOLD_LOAD = RPT_W'(HOLD_TICKS - 1);
  localparam logic [RPT_W-1:0] RPT_LOAD  = RPT_W'(RPT_TICKS - 1);
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             mismatch;
    logic             flip;

    // A matching sample restarts the integration, which is what rejects bounce.
    always_comb begin
      mismatch = s_norm[i] ^ level_q;
      flip     = 1'b0;
      cnt_d    = cnt_q;
      if (tick) begin
        if (!mismatch) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          flip  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        cnt_q     <= '0;
        level_q   <= LVL_RELEASED;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        level_q   <= level_q ^ flip;
        press_q   <= flip & (level_q == LVL_RELEASED);
        release_q <= flip & (level_q == LVL_PRESSED);
      end
    end

    assign LEVEL[i]   = level_q;
    assign PRESS[i]   = press_q;
    assign RELEASE[i] = release_q;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    logic [RPT_W-1:0] hold_q;
    logic             rpt_q;

    // Down-counter of held ticks; first terminal count after HOLD_TICKS,
    // then every RPT_TICKS. No repeat on the tick that releases the button.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        hold_q <= HOLD_LOAD;
        rpt_q  <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        if (level_q == LVL_RELEASED) begin
          hold_q <= HOLD_LOAD;
        end else if (tick) begin
          if (hold_q == '0) begin
            hold_q <= RPT_LOAD;
            rpt_q  <= ~flip;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
      end
    end

    assign REPEAT[i] = rpt_q;
`else
    assign REPEAT[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: table vectors, hand-written corner sequences and
// random stimulus against a sample-history reference model.
`timescale 1ns/1ps
module tb_btn_debounce_multi;

  localparam int N_CH       = 2;
  localparam int DIV_CNT    = 4;
  localparam int STABLE_N   = 3;
  localparam bit ACTIVE_LOW = 1'b1;
  localparam int HOLD       = 4;
  localparam int RPT        = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] BTN_RAW = 2'b11;
  logic [1:0] LEVEL, PRESS, RELEASE, REPEAT;
  logic       TICK;

  always #5 CLK = ~CLK;

  btn_debounce_multi #(
    .N_CH       (N_CH),
    .DIV_CNT    (DIV_CNT),
    .STABLE_N   (STABLE_N),
    .ACTIVE_LOW (ACTIVE_LOW),
    .HOLD_TICKS (HOLD),
    .RPT_TICKS  (RPT)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .BTN_RAW (BTN_RAW),
    .LEVEL   (LEVEL),
    .PRESS   (PRESS),
    .RELEASE (RELEASE),
    .REPEAT  (REPEAT),
    .TICK    (TICK)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: level flips once the last STABLE_N tick samples all
  // disagree with it; repeats are derived from the count of held ticks.
  int               n_edge;
  logic [1:0]       r1, r2;
  logic [STABLE_N-1:0] hist [N_CH];
  int               held [N_CH];
  logic [1:0]       m_level, m_press, m_rel, m_rep;
  logic             m_tick;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      n_edge  = 0;
      r1      = ACTIVE_LOW ? 2'b11 : 2'b00;
      r2      = r1;
      m_level = '0; m_press = '0; m_rel = '0; m_rep = '0; m_tick = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        hist[i] = '0;
        held[i] = 0;
      end
    end else begin
      bit upd;
      upd = (n_edge > 0) && (n_edge % DIV_CNT == 0);
      m_press = '0; m_rel = '0; m_rep = '0;
      if (upd) begin
        for (int i = 0; i < N_CH; i++) begin
          bit s, flip;
          s       = r2[i] ^ ACTIVE_LOW;
          hist[i] = {hist[i][STABLE_N-2:0], s};
          flip    = m_level[i] ? (hist[i] == '0) : (&hist[i]);
          if (m_level[i]) held[i]++;
          else            held[i] = 0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
          if (m_level[i] && !flip &&
              (held[i] == HOLD || (held[i] > HOLD && (held[i] - HOLD) % RPT == 0)))
            m_rep[i] = 1'b1;
`endif
          if (flip) begin
            m_level[i] = ~m_level[i];
            if (m_level[i]) m_press[i] = 1'b1;
            else            m_rel[i]   = 1'b1;
          end
        end
      end
      r2 = r1;
      r1 = BTN_RAW;
      n_edge++;
      m_tick = (n_edge % DIV_CNT == 0);
    end
  end

  always @(negedge CLK) begin
    chk("model_level",   LEVEL,   m_level);
    chk("model_press",   PRESS,   m_press);
    chk("model_release", RELEASE, m_rel);
    chk("model_repeat",  REPEAT,  m_rep);
    chk("model_tick",    TICK,    m_tick);
    chk("press_and_release_same_ch", PRESS & RELEASE, 0);
  end

  // Pulse bookkeeping for the hand-written sequences.
  int pc [2], rc [2], rp [2], rep_after_rel [2], press_cyc [2];
  bit rel_seen [2];
  bit both_p, both_r;
  int cyc = 0;
  int rep1_cyc [$];

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      pc[i] = 0; rc[i] = 0; rp[i] = 0; rep_after_rel[i] = 0; rel_seen[i] = 1'b0;
    end
    both_p = 1'b0; both_r = 1'b0;
    rep1_cyc.delete();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (PRESS[i]) begin pc[i]++; press_cyc[i] = cyc; end
        if (RELEASE[i]) begin rc[i]++; rel_seen[i] = 1'b1; end
        if (REPEAT[i]) begin
          rp[i]++;
          if (rel_seen[i]) rep_after_rel[i]++;
          if (i == 1) rep1_cyc.push_back(cyc);
        end
      end
      if (PRESS == 2'b11)   both_p = 1'b1;
      if (RELEASE == 2'b11) both_r = 1'b1;
    end
  endtask

  typedef struct {
    logic [1:0] raw;
    int         cycles;
    logic [1:0] exp_level;
    logic [1:0] exp_press;
    logic [1:0] exp_rel;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{2'b10, 20, 2'b01, 2'b01, 2'b00};
    vecs[1] = '{2'b00, 20, 2'b11, 2'b10, 2'b00};
    vecs[2] = '{2'b01, 20, 2'b10, 2'b00, 2'b01};
    vecs[3] = '{2'b11, 20, 2'b00, 2'b00, 2'b10};
    vecs[4] = '{2'b11, 20, 2'b00, 2'b00, 2'b00};
    vecs[5] = '{2'b10,  3, 2'b00, 2'b00, 2'b00};
    vecs[6] = '{2'b11, 20, 2'b00, 2'b00, 2'b00};

    // Reset with buttons idle, then tick phase.
    RST = 1'b0; BTN_RAW = 2'b11;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      chk("rst_outputs", {LEVEL, PRESS, RELEASE, REPEAT, TICK}, 0);
    end
    #2 RST = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      chk("tick_phase", TICK, (k % 4 == 0));
    end

    // Table-driven vectors.
    for (int v = 0; v < 7; v++) begin
      clr();
      BTN_RAW = vecs[v].raw;
      run(vecs[v].cycles);
      chk($sformatf("vec%0d_level", v), LEVEL, vecs[v].exp_level);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("vec%0d_press%0d", v, i),   pc[i], vecs[v].exp_press[i]);
        chk($sformatf("vec%0d_release%0d", v, i), rc[i], vecs[v].exp_rel[i]);
      end
    end

    // Bounce: 2 ticks low, 1 tick high, five times, never reaches 3.
    clr();
    for (int r = 0; r < 5; r++) begin
      BTN_RAW = 2'b10; run(8);
      BTN_RAW = 2'b11; run(4);
    end
    chk("bounce_level", LEVEL[0], 0);
    chk("bounce_press", pc[0], 0);
    BTN_RAW = 2'b10; run(20);
    chk("bounce_then_stable_level", LEVEL[0], 1);
    chk("bounce_then_stable_press", pc[0], 1);
    BTN_RAW = 2'b11; run(20);
    chk("bounce_release_level", LEVEL, 0);

    // Simultaneous press and release on both channels.
    clr(); BTN_RAW = 2'b00; run(20);
    chk("simul_press_seen", both_p, 1);
    chk("simul_press_level", LEVEL, 2'b11);
    clr(); BTN_RAW = 2'b11; run(20);
    chk("simul_release_seen", both_r, 1);
    chk("simul_release_level", LEVEL, 0);
    chk("simul_release_cnt0", rc[0], 1);
    chk("simul_release_cnt1", rc[1], 1);

    // Reset mid-debounce while ch0 stays held.
    clr(); BTN_RAW = 2'b10; run(10);
    chk("middeb_no_press_yet", pc[0], 0);
    #2 RST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("middeb_rst_outputs", {LEVEL, PRESS, RELEASE, REPEAT, TICK}, 0);
    end
    #2 RST = 1'b1;
    clr(); run(12);
    chk("middeb_no_early_press", pc[0], 0);
    chk("middeb_no_release", rc[0], 0);
    run(1);
    chk("middeb_press_at_3rd_tick", PRESS, 2'b01);
    BTN_RAW = 2'b11; run(20);

    // Auto-repeat on ch1 held for many ticks.
    clr(); BTN_RAW = 2'b01; run(100);
    BTN_RAW = 2'b11; run(30);
    chk("rpt_ch0_none", rp[0], 0);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    chk("rpt_seen_twice", rep1_cyc.size() >= 2, 1);
    if (rep1_cyc.size() >= 2) begin
      chk("rpt_first_gap", rep1_cyc[0] - press_cyc[1], HOLD * DIV_CNT);
      chk("rpt_second_gap", rep1_cyc[1] - rep1_cyc[0], RPT * DIV_CNT);
    end
    chk("rpt_after_release", rep_after_rel[1], 0);
`else
    chk("rpt_ch1_none", rp[1], 0);
`endif

    // Random stimulus with one reset in the middle.
    for (int seg = 0; seg < 80; seg++) begin
      BTN_RAW = 2'($urandom_range(0, 3));
      run($urandom_range(1, 40));
      if (seg == 40) begin
        #2 RST = 1'b0;
        @(negedge CLK);
        #2 RST = 1'b1;
      end
    end
    BTN_RAW = 2'b11; run(40);
    chk("random_final_level", LEVEL, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
